dmem_arbiter: RTL and testbench

- Two-master arbiter sharing the single DMEM port: separate read and write channels, one grant per channel per cycle.
- Typical masters: m0 = core load/store unit, m1 = debug/DMA requester.
- Routes the 1-cycle-latency DMEM read response back to the issuing master.
- Flags reads that get no response.
- Stalls reads that would return stale data because of the DMEM two-stage write pipeline.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 tb/tb_dmem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter for the shared DMEM port with write-pipeline hazard stalls and read response routing
module dmem_arbiter #(
  parameter int IDX_W = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_rd_valid,
  input  logic [31:0]   m0_rd_addr,
  output logic          m0_rd_gnt,
  output logic          m0_rd_ready,
  output logic          m0_rd_err,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m0_wr_valid,
  input  logic [31:0]   m0_wr_addr,
  input  logic [DW-1:0] m0_wr_data,
  input  logic [3:0]    m0_wr_strobe,
  output logic          m0_wr_gnt,
  input  logic          m1_rd_valid,
  input  logic [31:0]   m1_rd_addr,
  output logic          m1_rd_gnt,
  output logic          m1_rd_ready,
  output logic          m1_rd_err,
  output logic [DW-1:0] m1_rd_data,
  input  logic          m1_wr_valid,
  input  logic [31:0]   m1_wr_addr,
  input  logic [DW-1:0] m1_wr_data,
  input  logic [3:0]    m1_wr_strobe,
  output logic          m1_wr_gnt,
  output logic          dm_rd_valid,
  output logic [31:0]   dm_rd_addr,
  input  logic          dm_rd_ready,
  input  logic [DW-1:0] dm_rd_data,
  output logic          dm_wr_valid,
  output logic [31:0]   dm_wr_addr,
  output logic [DW-1:0] dm_wr_data,
  output logic [3:0]    dm_wr_strobe
);
  logic             r_wr_ptr, r_rd_ptr, r_hist_v, r_rsp_v, r_rsp_id;
  logic [IDX_W-1:0] r_hist_idx;
  logic             w_wg0, w_wg1, w_b0, w_b1, w_e0, w_e1, w_rg0, w_rg1, w_ok, w_bad;
  logic [IDX_W-1:0] w_widx;

  // write round-robin: the favoured master wins a tie
  always_comb begin
    w_wg0 = !rst && m0_wr_valid && (!r_wr_ptr || !m1_wr_valid);
    w_wg1 = !rst && m1_wr_valid && !w_wg0;
  end

  assign m0_wr_gnt    = w_wg0;
  assign m1_wr_gnt    = w_wg1;
  assign dm_wr_valid  = w_wg0 || w_wg1;
  assign dm_wr_addr   = w_wg1 ? m1_wr_addr : m0_wr_addr;
  assign dm_wr_data   = w_wg1 ? m1_wr_data : m0_wr_data;
  assign dm_wr_strobe = w_wg1 ? m1_wr_strobe : m0_wr_strobe;
  assign w_widx       = dm_wr_addr[IDX_W-1:0];

  // reads hitting a write still in the two-stage pipeline would see stale data, so they sit out arbitration
  always_comb begin
    w_b0  = (dm_wr_valid && m0_rd_addr[IDX_W-1:0] == w_widx) || (r_hist_v && m0_rd_addr[IDX_W-1:0] == r_hist_idx);
    w_b1  = (dm_wr_valid && m1_rd_addr[IDX_W-1:0] == w_widx) || (r_hist_v && m1_rd_addr[IDX_W-1:0] == r_hist_idx);
    w_e0  = !rst && m0_rd_valid && !w_b0;
    w_e1  = !rst && m1_rd_valid && !w_b1;
    w_rg0 = w_e0 && (!r_rd_ptr || !w_e1);
    w_rg1 = w_e1 && !w_rg0;
  end

  assign m0_rd_gnt   = w_rg0;
  assign m1_rd_gnt   = w_rg1;
  assign dm_rd_valid = w_rg0 || w_rg1;
  assign dm_rd_addr  = w_rg1 ? m1_rd_addr : m0_rd_addr;

  // route last cycle's read response (or its absence) to the master that issued it
  always_comb begin
    w_ok        = r_rsp_v && dm_rd_ready;
    w_bad       = r_rsp_v && !dm_rd_ready;
    m0_rd_ready = w_ok && !r_rsp_id;
    m1_rd_ready = w_ok && r_rsp_id;
    m0_rd_err   = w_bad && !r_rsp_id;
    m1_rd_err   = w_bad && r_rsp_id;
    m0_rd_data  = m0_rd_ready ? dm_rd_data : '0;
    m1_rd_data  = m1_rd_ready ? dm_rd_data : '0;
  end

  // rotation pointers move only on a grant; hazard history and outstanding read follow each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_hist_v   <= 1'b0;
      r_hist_idx <= '0;
      r_rsp_v    <= 1'b0;
      r_rsp_id   <= 1'b0;
    end else begin
      if (dm_wr_valid) r_wr_ptr <= w_wg0;
      if (dm_rd_valid) r_rd_ptr <= w_rg0;
      r_hist_v   <= dm_wr_valid;
      r_hist_idx <= w_widx;
      r_rsp_v    <= dm_rd_valid;
      r_rsp_id   <= w_rg1;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, table-driven and randomized checks of dmem_arbiter against a DMEM model and an architectural reference
module tb_dmem_arbiter;
  logic        clk = 0, rst = 1;
  logic        m0_rd_valid = 0, m1_rd_valid = 0, m0_wr_valid = 0, m1_wr_valid = 0;
  logic [31:0] m0_rd_addr = 0, m1_rd_addr = 0, m0_wr_addr = 0, m1_wr_addr = 0;
  logic [31:0] m0_wr_data = 0, m1_wr_data = 0;
  logic [3:0]  m0_wr_strobe = 0, m1_wr_strobe = 0;
  logic        m0_rd_gnt, m1_rd_gnt, m0_rd_ready, m1_rd_ready, m0_rd_err, m1_rd_err, m0_wr_gnt, m1_wr_gnt;
  logic [31:0] m0_rd_data, m1_rd_data;
  logic        dm_rd_valid, dm_rd_ready, dm_wr_valid;
  logic [31:0] dm_rd_addr, dm_rd_data, dm_wr_addr, dm_wr_data;
  logic [3:0]  dm_wr_strobe;
  int total = 0, bad = 0;

  dmem_arbiter #(.IDX_W(8), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_valid(m0_rd_valid), .m0_rd_addr(m0_rd_addr), .m0_rd_gnt(m0_rd_gnt), .m0_rd_ready(m0_rd_ready),
    .m0_rd_err(m0_rd_err), .m0_rd_data(m0_rd_data), .m0_wr_valid(m0_wr_valid), .m0_wr_addr(m0_wr_addr),
    .m0_wr_data(m0_wr_data), .m0_wr_strobe(m0_wr_strobe), .m0_wr_gnt(m0_wr_gnt),
    .m1_rd_valid(m1_rd_valid), .m1_rd_addr(m1_rd_addr), .m1_rd_gnt(m1_rd_gnt), .m1_rd_ready(m1_rd_ready),
    .m1_rd_err(m1_rd_err), .m1_rd_data(m1_rd_data), .m1_wr_valid(m1_wr_valid), .m1_wr_addr(m1_wr_addr),
    .m1_wr_data(m1_wr_data), .m1_wr_strobe(m1_wr_strobe), .m1_wr_gnt(m1_wr_gnt),
    .dm_rd_valid(dm_rd_valid), .dm_rd_addr(dm_rd_addr), .dm_rd_ready(dm_rd_ready), .dm_rd_data(dm_rd_data),
    .dm_wr_valid(dm_wr_valid), .dm_wr_addr(dm_wr_addr), .dm_wr_data(dm_wr_data), .dm_wr_strobe(dm_wr_strobe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initw(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {16'h0, b, ~b};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  // DMEM: 1-cycle read latency, region 1 unmapped, writes land one cycle after issue
  logic [31:0] mem [256];
  logic [31:0] arch [256];
  logic [31:0] rdq, pw_a, pw_d;
  logic        rrdy = 0, pw_v = 0;
  logic [3:0]  pw_s;
  assign dm_rd_ready = rrdy;
  assign dm_rd_data  = rdq;
  always @(posedge clk) begin
    rrdy <= dm_rd_valid && dm_rd_addr[11:10] != 2'd1;
    rdq  <= mem[dm_rd_addr[7:0]];
    pw_v <= dm_wr_valid;
    pw_a <= dm_wr_addr;
    pw_d <= dm_wr_data;
    pw_s <= dm_wr_strobe;
    if (pw_v && pw_a[11:10] != 2'd1)
      for (int b = 0; b < 4; b++) if (pw_s[b]) mem[pw_a[7:0]][b*8 +: 8] <= pw_d[b*8 +: 8];
  end

  // reference: writes take effect architecturally at grant; a correct arbiter makes every read see that view
  int fw, fr, ww, rw, pid;
  logic hv, pv, pmap;
  logic [7:0] hidx, widx;
  logic [31:0] pdata;
  logic [31:0] wa [2], wd [2], ra [2], rdat [2];
  logic [3:0] ws [2];
  logic wv [2], rv [2], el [2], rr [2], re [2];
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_gnt", {26'h0, m0_rd_gnt, m1_rd_gnt, m0_wr_gnt, m1_wr_gnt, dm_rd_valid, dm_wr_valid}, 0);
      chk("rst_rsp", {28'h0, m0_rd_ready, m1_rd_ready, m0_rd_err, m1_rd_err}, 0);
      chk("rst_data", m0_rd_data | m1_rd_data, 0);
      fw = 0; fr = 0; hv = 0; pv = 0;
    end else begin
      wv[0] = m0_wr_valid; wv[1] = m1_wr_valid; wa[0] = m0_wr_addr; wa[1] = m1_wr_addr;
      wd[0] = m0_wr_data; wd[1] = m1_wr_data; ws[0] = m0_wr_strobe; ws[1] = m1_wr_strobe;
      rv[0] = m0_rd_valid; rv[1] = m1_rd_valid; ra[0] = m0_rd_addr; ra[1] = m1_rd_addr;
      rr[0] = m0_rd_ready; rr[1] = m1_rd_ready; re[0] = m0_rd_err; re[1] = m1_rd_err;
      rdat[0] = m0_rd_data; rdat[1] = m1_rd_data;
      ww = (wv[0] && wv[1]) ? fw : wv[0] ? 0 : wv[1] ? 1 : -1;
      widx = ww >= 0 ? wa[ww][7:0] : 8'h0;
      for (int m = 0; m < 2; m++)
        el[m] = rv[m] && !((ww >= 0 && ra[m][7:0] == widx) || (hv && ra[m][7:0] == hidx));
      rw = (el[0] && el[1]) ? fr : el[0] ? 0 : el[1] ? 1 : -1;
      chk("m0_wr_gnt", m0_wr_gnt, ww == 0);
      chk("m1_wr_gnt", m1_wr_gnt, ww == 1);
      chk("m0_rd_gnt", m0_rd_gnt, rw == 0);
      chk("m1_rd_gnt", m1_rd_gnt, rw == 1);
      chk("dm_wr_valid", dm_wr_valid, ww >= 0);
      chk("dm_rd_valid", dm_rd_valid, rw >= 0);
      if (ww >= 0) begin
        chk("dm_wr_addr", dm_wr_addr, wa[ww]);
        chk("dm_wr_data", dm_wr_data, wd[ww]);
        chk("dm_wr_strobe", dm_wr_strobe, ws[ww]);
      end
      if (rw >= 0) chk("dm_rd_addr", dm_rd_addr, ra[rw]);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_rd_ready", m), rr[m], pv && pmap && pid == m);
        chk($sformatf("m%0d_rd_err", m), re[m], pv && !pmap && pid == m);
        chk($sformatf("m%0d_rd_data", m), rdat[m], (pv && pmap && pid == m) ? pdata : 0);
      end
      pv = rw >= 0;
      if (pv) begin
        pid = rw; fr = 1 - rw;
        pmap = ra[rw][11:10] != 2'd1;
        pdata = arch[ra[rw][7:0]];
      end
      if (ww >= 0) begin
        fw = 1 - ww;
        if (wa[ww][11:10] != 2'd1)
          for (int b = 0; b < 4; b++) if (ws[ww][b]) arch[wa[ww][7:0]][b*8 +: 8] = wd[ww][b*8 +: 8];
      end
      hv = ww >= 0; hidx = widx;
    end
  end

  task automatic settle();
    #2;
  endtask

  task automatic nxt();
    logic a, b, c, d;
    a = m0_rd_gnt; b = m1_rd_gnt; c = m0_wr_gnt; d = m1_wr_gnt;
    @(posedge clk); #1;
    if (a) m0_rd_valid = 0;
    if (b) m1_rd_valid = 0;
    if (c) m0_wr_valid = 0;
    if (d) m1_wr_valid = 0;
  endtask

  function automatic logic [31:0] raddr();
    int r;
    r = $urandom_range(0, 11);
    return r < 8 ? r : 32'h400 + r - 8;
  endfunction

  typedef struct {logic m0v, m1v, g0, g1;} wrow_t;
  wrow_t tab [13];
  int n0, n1;

  initial begin
    for (int i = 0; i < 8; i++) tab[i] = '{1'b1, 1'b1, i % 2 == 0, i % 2 == 1};
    tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tab[10] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tab[11] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tab[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 256; i++) begin
      mem[i] = initw(i);
      arch[i] = initw(i);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    m0_rd_valid = 1; m0_rd_addr = 32'h10; m1_rd_valid = 1; m1_rd_addr = 32'h20;
    settle();
    chk("t1_c0_m0_gnt", m0_rd_gnt, 1);
    chk("t1_c0_m1_gnt", m1_rd_gnt, 0);
    nxt(); settle();
    chk("t1_c1_m1_gnt", m1_rd_gnt, 1);
    chk("t1_c1_m0_ready", m0_rd_ready, 1);
    chk("t1_c1_m0_data", m0_rd_data, initw(16));
    chk("t1_c1_m1_data", m1_rd_data, 0);
    nxt(); settle();
    chk("t1_c2_m1_ready", m1_rd_ready, 1);
    chk("t1_c2_m1_data", m1_rd_data, initw(32));
    chk("t1_c2_m0_data", m0_rd_data, 0);
    nxt();
    m1_wr_valid = 1; m1_wr_addr = 32'h05; m1_wr_data = 32'hA5A5A5A5; m1_wr_strobe = 4'hF;
    m0_rd_valid = 1; m0_rd_addr = 32'h05;
    settle();
    chk("t2_t0_wr_gnt", m1_wr_gnt, 1);
    chk("t2_t0_rd_gnt", m0_rd_gnt, 0);
    nxt(); settle();
    chk("t2_t1_rd_gnt", m0_rd_gnt, 0);
    nxt(); settle();
    chk("t2_t2_rd_gnt", m0_rd_gnt, 1);
    nxt(); settle();
    chk("t2_t3_ready", m0_rd_ready, 1);
    chk("t2_t3_data", m0_rd_data, 32'hA5A5A5A5);
    nxt();
    m0_rd_valid = 1; m0_rd_addr = 32'h400;
    settle();
    chk("t3_gnt", m0_rd_gnt, 1);
    nxt(); settle();
    chk("t3_err", m0_rd_err, 1);
    chk("t3_ready", m0_rd_ready, 0);
    nxt(); settle();
    chk("t3_err_clr", m0_rd_err, 0);
    rst = 1;
    nxt();
    rst = 0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 13; i++) begin
      m0_wr_valid = tab[i].m0v; m0_wr_addr = 32'h30 + i; m0_wr_data = $urandom; m0_wr_strobe = 4'hF;
      m1_wr_valid = tab[i].m1v; m1_wr_addr = 32'h40 + i; m1_wr_data = $urandom; m1_wr_strobe = 4'hF;
      settle();
      chk($sformatf("tab%0d_g0", i), m0_wr_gnt, tab[i].g0);
      chk($sformatf("tab%0d_g1", i), m1_wr_gnt, tab[i].g1);
      chk($sformatf("tab%0d_dmv", i), dm_wr_valid, tab[i].g0 | tab[i].g1);
      if (i < 8) begin
        n0 += int'(m0_wr_gnt);
        n1 += int'(m1_wr_gnt);
      end
      @(posedge clk); #1;
    end
    m0_wr_valid = 0; m1_wr_valid = 0;
    chk("tab_cnt_m0", n0, 4);
    chk("tab_cnt_m1", n1, 4);
    m0_wr_valid = 1; m0_wr_addr = 32'h07; m0_wr_data = 32'h12345678; m0_wr_strobe = 4'h3;
    settle();
    nxt(); nxt();
    m0_rd_valid = 1; m0_rd_addr = 32'h07;
    settle();
    chk("t5_gnt", m0_rd_gnt, 1);
    nxt(); settle();
    chk("t5_data", m0_rd_data, 32'h00005678);
    nxt();
    m0_rd_valid = 1; m0_rd_addr = 32'h11;
    settle();
    chk("t6_gnt", m0_rd_gnt, 1);
    nxt();
    rst = 1;
    settle();
    chk("t6_rst_ready", m0_rd_ready, 0);
    chk("t6_rst_err", m0_rd_err, 0);
    @(posedge clk); #1;
    rst = 0;
    settle();
    chk("t6_rel_ready", m0_rd_ready, 0);
    chk("t6_rel_err", m0_rd_err, 0);
    nxt();
    m0_rd_valid = 1; m0_rd_addr = 32'h12; m1_rd_valid = 1; m1_rd_addr = 32'h13;
    settle();
    chk("t6_m0_first", m0_rd_gnt, 1);
    chk("t6_m1_wait", m1_rd_gnt, 0);
    nxt(); settle(); nxt();
    for (int c = 0; c < 3000; c++) begin
      if (!m0_rd_valid && $urandom_range(0, 1) == 1) begin m0_rd_valid = 1; m0_rd_addr = raddr(); end
      if (!m1_rd_valid && $urandom_range(0, 1) == 1) begin m1_rd_valid = 1; m1_rd_addr = raddr(); end
      if (!m0_wr_valid && $urandom_range(0, 1) == 1) begin
        m0_wr_valid = 1; m0_wr_addr = raddr(); m0_wr_data = $urandom; m0_wr_strobe = 4'($urandom);
      end
      if (!m1_wr_valid && $urandom_range(0, 1) == 1) begin
        m1_wr_valid = 1; m1_wr_addr = raddr(); m1_wr_data = $urandom; m1_wr_strobe = 4'($urandom);
      end
      if ($urandom_range(0, 249) == 0) rst = 1;
      settle();
      nxt();
      rst = 0;
    end
    m0_rd_valid = 0; m1_rd_valid = 0; m0_wr_valid = 0; m1_wr_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
